// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
package hazard_pkg;

  localparam int unsigned REG_W = 5;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Fields tracked for every shadow stage.
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             is_load;
    logic             mem_access;
  } stage_t;

  // EX additionally keeps its source indices for the forwarding compare.
  typedef struct packed {
    stage_t           base;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
  } ex_stage_t;

  localparam int unsigned STAGE_W    = $bits(stage_t);
  localparam int unsigned EX_STAGE_W = $bits(ex_stage_t);

  // Operand select for one source: MEM ALU result beats WB; loads in MEM have no data yet.
  function automatic logic [1:0] fwd_sel(input stage_t mem, input stage_t wb,
                                         input logic [REG_W-1:0] rs);
    if (mem.valid && mem.reg_write && !mem.is_load && (mem.rd != '0) && (mem.rd == rs))
      return FWD_MEM;
    if (wb.valid && wb.reg_write && (wb.rd != '0) && (wb.rd == rs))
      return FWD_WB;
    return FWD_REG;
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One shadow pipeline stage with hold and bubble control.
module hazard_stage_reg #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         hold,
  input  logic         bubble,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Hold wins over bubble so a frozen stage keeps its instruction.
  always_ff @(posedge clk) begin
    if (!reset)      q <= '0;
    else if (!hold)  q <= bubble ? '0 : d;
  end

endmodule

// File: rtl/hazard_controller.sv
// Hazard detection, operand forwarding and stall/flush control for the 5-stage core.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_reg_write,
  input  logic             id_is_load,
  input  logic             id_mem_access,
  input  logic             ex_pc_src,
  input  logic             mem_ready,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_w,
  output logic [CNT_W-1:0] load_use_count,
  output logic [CNT_W-1:0] flush_count
);

  ex_stage_t               ex_d, ex;
  stage_t                  mem, wb;
  logic [EX_STAGE_W-1:0]   ex_q;
  logic [STAGE_W-1:0]      mem_q, wb_q;
  logic                    mem_wait, branch, load_use;
  logic                    lu_take, br_take;
  logic                    unused_wb;

  // Decode fields captured into EX.
  always_comb begin
    ex_d                 = '0;
    ex_d.base.valid      = id_valid;
    ex_d.base.rd         = id_rd;
    ex_d.base.reg_write  = id_reg_write;
    ex_d.base.is_load    = id_is_load;
    ex_d.base.mem_access = id_mem_access;
    ex_d.rs1             = id_rs1;
    ex_d.rs2             = id_rs2;
  end

  hazard_stage_reg #(.W(EX_STAGE_W)) u_ex (
    .clk(clk), .reset(reset), .hold(mem_wait), .bubble(flush_e),
    .d(ex_d), .q(ex_q)
  );

  hazard_stage_reg #(.W(STAGE_W)) u_mem (
    .clk(clk), .reset(reset), .hold(mem_wait), .bubble(1'b0),
    .d(ex.base), .q(mem_q)
  );

  hazard_stage_reg #(.W(STAGE_W)) u_wb (
    .clk(clk), .reset(reset), .hold(1'b0), .bubble(mem_wait),
    .d(mem), .q(wb_q)
  );

  assign ex  = ex_stage_t'(ex_q);
  assign mem = stage_t'(mem_q);
  assign wb  = stage_t'(wb_q);

  // WB only ever supplies data; its load/memory flags are carried but not consulted.
  assign unused_wb = wb.is_load ^ wb.mem_access;

  // Operand forwarding selects.
  assign forward_a = fwd_sel(mem, wb, ex.rs1);
  assign forward_b = fwd_sel(mem, wb, ex.rs2);

  // Raw hazard conditions.
  assign mem_wait = mem.valid & mem.mem_access & ~mem_ready;
  assign branch   = ex.base.valid & ex_pc_src;
  assign load_use = ex.base.valid & ex.base.is_load & id_valid & (ex.base.rd != '0) &
                    ((ex.base.rd == id_rs1) | (ex.base.rd == id_rs2));

  // Prioritised stall/flush control.
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    lu_take = 1'b0;
    br_take = 1'b0;
    if (mem_wait) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (branch) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
      br_take = 1'b1;
    end else if (load_use) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
      lu_take = 1'b1;
    end
  end

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      load_use_count <= '0;
      flush_count    <= '0;
    end else begin
      if (lu_take && (load_use_count != '1)) load_use_count <= load_use_count + CNT_W'(1);
      if (br_take && (flush_count != '1))    flush_count    <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed scoreboard bench for hazard_controller (16-bit and 3-bit counter instances).
module tb_hazard_controller;

  localparam logic [10:0] O_NONE = 11'b00_00_0000_000;
  localparam logic [10:0] O_WAIT = 11'b00_00_1111_001;
  localparam logic [10:0] O_LU   = 11'b00_00_1100_010;
  localparam logic [10:0] O_BR   = 11'b00_00_0000_110;

  logic        clk, reset;
  logic        id_valid, id_reg_write, id_is_load, id_mem_access, ex_pc_src, mem_ready;
  logic [4:0]  id_rs1, id_rs2, id_rd;

  logic [1:0]  fa, fb, sfa, sfb;
  logic        sf, sd, se, sm, fd, fe, fw;
  logic        ssf, ssd, sse, ssm, sfd, sfe, sfw;
  logic [15:0] lu_cnt, fl_cnt;
  logic [2:0]  s_lu_cnt, s_fl_cnt;
  logic [10:0] obs, obs_sat;

  int          errors = 0;
  int          checks = 0;
  logic [10:0] exp_q[$];
  string       tag_q[$];

  hazard_controller u_dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .id_mem_access(id_mem_access), .ex_pc_src(ex_pc_src), .mem_ready(mem_ready),
    .forward_a(fa), .forward_b(fb), .stall_f(sf), .stall_d(sd), .stall_e(se), .stall_m(sm),
    .flush_d(fd), .flush_e(fe), .flush_w(fw),
    .load_use_count(lu_cnt), .flush_count(fl_cnt)
  );

  hazard_controller #(.CNT_W(3)) u_sat (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .id_mem_access(id_mem_access), .ex_pc_src(ex_pc_src), .mem_ready(mem_ready),
    .forward_a(sfa), .forward_b(sfb), .stall_f(ssf), .stall_d(ssd), .stall_e(sse),
    .stall_m(ssm), .flush_d(sfd), .flush_e(sfe), .flush_w(sfw),
    .load_use_count(s_lu_cnt), .flush_count(s_fl_cnt)
  );

  assign obs     = {fa, fb, sf, sd, se, sm, fd, fe, fw};
  assign obs_sat = {sfa, sfb, ssf, ssd, sse, ssm, sfd, sfe, sfw};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic rw, input logic ld,
                       input logic ma, input logic pc, input logic mr);
    id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rd = rd; id_reg_write = rw;
    id_is_load = ld; id_mem_access = ma; ex_pc_src = pc; mem_ready = mr;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Push the expected output word, let the combinational outputs settle, then pop and compare.
  task automatic cyc(input string tag, input logic [10:0] e);
    logic [10:0] x;
    string       t;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #2;
    x = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (obs === x) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", t, obs, x);
    end
    checks++;
    assert (obs_sat === x) else begin
      errors++;
      $error("FAIL %s_sat: observed %b expected %b", t, obs_sat, x);
    end
  endtask

  task automatic check_cnt(input string tag, input int unsigned o, input int unsigned e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, o, e);
    end
  endtask

  initial begin
    reset = 1'b0;
    idle();
    @(negedge clk); cyc("reset_outs", O_NONE);
    check_cnt("reset_lu", lu_cnt, 0); check_cnt("reset_fl", fl_cnt, 0);

    // ALU back-to-back: add x5 ; sub x7, x5, x3
    @(negedge clk); reset = 1'b1; drive(1, 5'd1, 5'd2, 5'd5, 1, 0, 0, 0, 1); cyc("alu_prod", O_NONE);
    @(negedge clk); drive(1, 5'd5, 5'd3, 5'd7, 1, 0, 0, 0, 1); cyc("alu_cons_dec", O_NONE);
    @(negedge clk); idle(); cyc("alu_fwd_mem", 11'b10_00_0000_000);
    @(negedge clk); idle(); cyc("alu_drain", O_NONE);

    // One-instruction gap: producer x5, independent, consumer rs2 = x5
    @(negedge clk); drive(1, 5'd1, 5'd2, 5'd5, 1, 0, 0, 0, 1);
    @(negedge clk); drive(1, 5'd9, 5'd10, 5'd8, 1, 0, 0, 0, 1);
    @(negedge clk); drive(1, 5'd12, 5'd5, 5'd11, 1, 0, 0, 0, 1); cyc("gap_pre", O_NONE);
    @(negedge clk); idle(); cyc("gap_fwd_wb", 11'b00_01_0000_000);
    @(negedge clk); idle();

    // Both MEM and WB write x5: MEM wins
    @(negedge clk); drive(1, 5'd1, 5'd2, 5'd5, 1, 0, 0, 0, 1);
    @(negedge clk); drive(1, 5'd3, 5'd4, 5'd5, 1, 0, 0, 0, 1);
    @(negedge clk); drive(1, 5'd6, 5'd5, 5'd12, 1, 0, 0, 0, 1);
    @(negedge clk); idle(); cyc("mem_over_wb", 11'b00_10_0000_000);
    @(negedge clk); idle();

    // Load-use: lw x6 ; add x13, x6, x7
    @(negedge clk); drive(1, 5'd1, 5'd0, 5'd6, 1, 1, 1, 0, 1); cyc("lu_load_dec", O_NONE);
    @(negedge clk); drive(1, 5'd6, 5'd7, 5'd13, 1, 0, 0, 0, 1); cyc("lu_stall", O_LU);
    @(negedge clk); cyc("lu_bubble", O_NONE); check_cnt("lu_count_1", lu_cnt, 1);
    @(negedge clk); idle(); cyc("lu_fwd_wb", 11'b01_00_0000_000);
    @(negedge clk); idle();

    // Taken branch while a load-use sits in decode
    @(negedge clk); drive(1, 5'd1, 5'd0, 5'd6, 1, 1, 1, 0, 1); cyc("br_load_dec", O_NONE);
    @(negedge clk); drive(1, 5'd6, 5'd0, 5'd14, 1, 0, 0, 1, 1); cyc("br_over_lu", O_BR);
    @(negedge clk); idle(); cyc("br_after", O_NONE);
    check_cnt("br_fl_count", fl_cnt, 1); check_cnt("br_lu_count", lu_cnt, 1);
    @(negedge clk); idle();

    // Store in MEM waits 3 cycles with a taken branch behind it in EX
    @(negedge clk); drive(1, 5'd1, 5'd2, 5'd0, 0, 0, 1, 0, 1);
    @(negedge clk); drive(1, 5'd3, 5'd4, 5'd0, 0, 0, 0, 0, 1); cyc("wait_pre", O_NONE);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0); cyc("mem_wait", O_WAIT);
    end
    @(negedge clk); drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1); cyc("br_after_wait", O_BR);
    @(negedge clk); idle(); cyc("wait_done", O_NONE); check_cnt("wait_fl_count", fl_cnt, 2);

    // x0 never forwards or stalls
    @(negedge clk); drive(1, 5'd1, 5'd2, 5'd0, 1, 0, 0, 0, 1);
    @(negedge clk); drive(1, 5'd0, 5'd0, 5'd16, 1, 0, 0, 0, 1);
    @(negedge clk); idle(); cyc("x0_no_fwd", O_NONE);
    @(negedge clk); drive(1, 5'd1, 5'd0, 5'd0, 1, 1, 1, 0, 1);
    @(negedge clk); drive(1, 5'd0, 5'd0, 5'd17, 1, 0, 0, 0, 1); cyc("x0_no_stall", O_NONE);
    @(negedge clk); idle(); check_cnt("x0_lu_count", lu_cnt, 1);

    // Reset asserted in the middle of a memory wait
    @(negedge clk); drive(1, 5'd1, 5'd2, 5'd0, 0, 0, 1, 0, 1);
    @(negedge clk); idle();
    @(negedge clk); drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0); cyc("wait_pre_reset", O_WAIT);
    @(negedge clk); reset = 1'b0; drive(1, 5'd6, 5'd6, 5'd5, 1, 1, 1, 1, 0); cyc("wait_in_reset", O_WAIT);
    @(negedge clk); reset = 1'b1; cyc("after_reset", O_NONE);
    check_cnt("rst_lu", lu_cnt, 0); check_cnt("rst_fl", fl_cnt, 0);
    check_cnt("rst_sat_lu", s_lu_cnt, 0); check_cnt("rst_sat_fl", s_fl_cnt, 0);
    repeat (3) begin @(negedge clk); idle(); end

    // Ten load-use events, then ten branch events
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); drive(1, 5'd1, 5'd0, 5'd6, 1, 1, 1, 0, 1);
      @(negedge clk); drive(1, 5'd6, 5'd0, 5'd13, 1, 0, 0, 0, 1); cyc("lu_loop", O_LU);
    end
    repeat (2) begin @(negedge clk); idle(); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); drive(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1);
    end
    @(negedge clk); idle(); #2;
    check_cnt("lu_count_10", lu_cnt, 10);
    check_cnt("fl_count_10", fl_cnt, 10);
    check_cnt("sat_lu", s_lu_cnt, 7);
    check_cnt("sat_fl", s_fl_cnt, 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline hazard and forwarding controller for the five-stage RV32I core. It keeps a shadow copy of destination and source register fields for the EX, MEM and WB stages. From that state it drives the 2-bit select inputs of the two EX-stage operand 3:1 multiplexers, along with the stall and flush enables of the pipeline registers. It sits beside the datapath, taking decode-stage register fields in and sending control out; it carries no 32-bit data.

## Interface
Parameters:
- CNT_W, 16, width of the saturating event counters

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- id_valid  in  1  decode stage holds a real instruction
- id_rs1, id_rs2  in  5  decode source register indices
- id_rd  in  5  decode destination register index
- id_reg_write  in  1  decode instruction writes the register file
- id_is_load  in  1  decode instruction is a load
- id_mem_access  in  1  decode instruction is a load or store
- ex_pc_src  in  1  branch or jump taken, resolved in EX
- mem_ready  in  1  data memory completes the access this cycle
- forward_a, forward_b  out  2  operand mux selects: 00 register file, 01 WB result, 10 MEM ALU result
- stall_f, stall_d, stall_e, stall_m  out  1  hold the named pipeline register
- flush_d, flush_e, flush_w  out  1  load a bubble into the named pipeline register
- load_use_count, flush_count  out  CNT_W  saturating event counters

## Operation
Shadow state:
- Per stage: valid, rd, reg_write, is_load, mem_access.
- EX additionally stores rs1 and rs2.
- Reset clears every valid bit and both counters. Every output then reads 0, and forward_a/forward_b read 00.

Forwarding (combinational from shadow state):
- forward_a = 10 when mem.valid, mem.reg_write, !mem.is_load, mem.rd != 0 and mem.rd == ex.rs1.
- Otherwise forward_a = 01 when wb.valid, wb.reg_write, wb.rd != 0 and wb.rd == ex.rs1.
- Otherwise forward_a = 00.
- forward_b is identical using ex.rs2.
- MEM has priority over WB. Encoding 11 is never driven.

Hazard conditions:
- mem_wait = mem.valid & mem.mem_access & !mem_ready.
- branch = ex.valid & ex_pc_src.
- load_use = ex.valid & ex.is_load & id_valid & ex.rd != 0 & (ex.rd == id_rs1 | ex.rd == id_rs2).

Control, in strict priority order:
- mem_wait: stall_f, stall_d, stall_e and stall_m = 1; flush_w = 1; all other outputs 0. EX and MEM shadow stages hold, and WB shadow takes a bubble. A pending branch or load-use is deferred, because EX is frozen and re-evaluates next cycle.
- branch: flush_d = 1 and flush_e = 1. The load-use stall is suppressed because the dependent instruction is discarded.
- load_use: stall_f = 1, stall_d = 1, flush_e = 1.
- Otherwise all stall and flush outputs are 0.

Shadow advance when not in mem_wait:
- EX <= decode fields, or a bubble when flush_e is asserted.
- MEM <= EX.
- WB <= MEM.

Counters:
- load_use_count increments on each cycle where the load_use action is taken.
- flush_count increments on each cycle where the branch action is taken.
- Both saturate at all-ones and never wrap.

## Timing
- Forward selects and stall/flush outputs are combinational from registered shadow state plus the id_* and mem_ready inputs, and are valid in the same cycle. They have no registered latency.
- A load-use stall lasts exactly one cycle: next cycle the load is in MEM and its result forwards from WB one cycle later.
- A memory wait of N cycles asserts the stall signals for N consecutive cycles, then releases in the cycle mem_ready is high.
- A branch flush lasts one cycle per taken branch.
- Reset asserted mid-stall clears all shadow state at the next edge. Outputs are all 0 in the following cycle, regardless of inputs.
- rd == 0 never forwards and never stalls.

## Structure
- hazard_pkg holds:
  - FWD_REG = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10
  - the stage-record field widths
- One sub-module, hazard_stage_reg, implements one shadow stage register with hold, bubble and reset inputs. It is instantiated for EX, MEM and WB.

## Test plan
- ALU back-to-back: add x5 then sub using x5 as rs1 -> forward_a = 10 in the sub's EX cycle; forward_b = 00.
- Gap of one instruction: x5 producer, independent op, consumer using x5 as rs2 -> forward_b = 01. If MEM also writes x5, forward_b = 10.
- Load-use: lw x6 then add using x6 -> one cycle of stall_f = stall_d = flush_e = 1. Next cycle forward = 01. load_use_count = 1.
- Taken branch with load-use in decode: ex_pc_src = 1 -> flush_d = flush_e = 1 and stall_f = 0. flush_count increments; load_use_count is unchanged.
- Memory wait: store in MEM with mem_ready held low for 3 cycles -> stall_f/d/e/m and flush_w high for exactly 3 cycles. A branch in EX flushes in the cycle after release.
- Writes to x0, reset mid-wait, and counters preset near the top -> no forwarding for x0; all outputs 0 after reset; counters stop at 16'hFFFF.
